// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_BAD   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_e;

  // Position of the set bit in a one-hot 4-bit vector (0 when none set).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment to BCD decoder.
// Optional feature macro: SSD_CAPTURE_HEX_EN (adds A, b, C, d, E, F decode).
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       blank_o,
  output logic       invalid_o
);

  // Map each recognised pattern to its code; everything else is flagged invalid.
  always_comb begin
    code_o    = DIG_BAD;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: begin
        code_o  = DIG_BLANK;
        blank_o = 1'b1;
      end
`ifdef SSD_CAPTURE_HEX_EN
      SEG_A:     code_o = 4'hA;
      SEG_B:     code_o = 4'hB;
      SEG_C:     code_o = 4'hC;
      SEG_D:     code_o = 4'hD;
      SEG_E:     code_o = 4'hE;
      SEG_F:     code_o = 4'hF;
`endif
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// Passive receiver for a multiplexed four-digit seven-segment bus.
// Samples each digit once its anode and cathodes have settled, assembles
// four-digit frames and publishes a frame after it repeats unchanged.
// Optional feature macro: SSD_CAPTURE_HEX_EN (hex digit decode, see ssd_seg_decode).
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led_anodes,
  input  logic [6:0] led_cathodes,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [3:0] val4,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       scan_err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);

  cap_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cath_q, cath_d;
  logic          multi_q, multi_d;
  logic          scan_err_q, scan_err_d;

  logic [15:0]   work_code_q, work_code_d;
  logic [3:0]    work_blank_q, work_blank_d;
  logic [15:0]   ref_code_q, ref_code_d;
  logic [3:0]    ref_blank_q, ref_blank_d;
  logic [3:0]    seen_q, seen_d;
  logic [MW-1:0] match_q, match_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    blank_q, blank_d;
  logic          frame_valid_q, frame_valid_d;
  logic          seg_err_q, seg_err_d;

  logic [3:0]    anodes_low;
  logic          single;
  logic          multi;
  logic          sample;
  logic [1:0]    slot;
  logic [3:0]    dec_code;
  logic          dec_blank;
  logic          dec_invalid;

  // Classify the anode bus: one digit driven, none driven, or an illegal overlap.
  always_comb begin
    anodes_low = ~led_anodes;
    single     = (anodes_low != 4'd0) && ((anodes_low & (anodes_low - 4'd1)) == 4'd0);
    multi      = (anodes_low != 4'd0) && !single;
    slot       = onehot_index(~anode_q);
  end

  // The held cathodes equal the live bus whenever a sample is taken.
  ssd_seg_decode u_decode (
    .seg_i     (cath_q),
    .code_o    (dec_code),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  // Settle FSM: wait for a steady anode/cathode pair, sample once, then hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    anode_d    = anode_q;
    cath_d     = cath_q;
    sample     = 1'b0;
    multi_d    = multi;
    scan_err_d = multi && !multi_q;
    case (state_q)
      ST_IDLE: begin
        if (single) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(1);
          anode_d = led_anodes;
          cath_d  = led_cathodes;
        end
      end
      ST_SETTLE: begin
        if (!single) begin
          state_d = ST_IDLE;
        end else if ((led_anodes != anode_q) || (led_cathodes != cath_q)) begin
          cnt_d   = CW'(1);
          anode_d = led_anodes;
          cath_d  = led_cathodes;
        end else if (cnt_q == SETTLE_C) begin
          sample  = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!single) begin
          state_d = ST_IDLE;
        end else if (led_anodes != anode_q) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(1);
          anode_d = led_anodes;
          cath_d  = led_cathodes;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame assembly, repeat detection against the reference frame, and publish.
  always_comb begin
    logic [15:0]   nxt_code;
    logic [3:0]    nxt_blank;
    logic [3:0]    nxt_seen;
    logic [MW-1:0] nxt_match;

    nxt_code      = work_code_q;
    nxt_blank     = work_blank_q;
    nxt_seen      = seen_q;
    nxt_match     = match_q;
    ref_code_d    = ref_code_q;
    ref_blank_d   = ref_blank_q;
    val_d         = val_q;
    blank_d       = blank_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;

    if (sample) begin
      nxt_code[{slot, 2'b00} +: 4] = dec_code;
      nxt_blank[slot]              = dec_blank;
      nxt_seen[slot]               = 1'b1;
      seg_err_d                    = dec_invalid;
    end

    work_code_d  = nxt_code;
    work_blank_d = nxt_blank;
    seen_d       = nxt_seen;

    if (sample && (nxt_seen == 4'hF)) begin
      seen_d = 4'h0;
      if ((nxt_code == ref_code_q) && (nxt_blank == ref_blank_q)) begin
        if (match_q != MATCH_MAX) nxt_match = match_q + MW'(1);
      end else begin
        ref_code_d  = nxt_code;
        ref_blank_d = nxt_blank;
        nxt_match   = MW'(1);
      end
      if (nxt_match == MATCH_MAX) begin
        val_d         = nxt_code;
        blank_d       = nxt_blank;
        frame_valid_d = 1'b1;
      end
    end

    match_d = nxt_match;
  end

  // State and datapath registers; reset drops any partial frame at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      anode_q       <= 4'hF;
      cath_q        <= SEG_BLANK;
      multi_q       <= 1'b0;
      scan_err_q    <= 1'b0;
      work_code_q   <= '0;
      work_blank_q  <= '0;
      ref_code_q    <= '0;
      ref_blank_q   <= '0;
      seen_q        <= '0;
      match_q       <= '0;
      val_q         <= '0;
      blank_q       <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      anode_q       <= anode_d;
      cath_q        <= cath_d;
      multi_q       <= multi_d;
      scan_err_q    <= scan_err_d;
      work_code_q   <= work_code_d;
      work_blank_q  <= work_blank_d;
      ref_code_q    <= ref_code_d;
      ref_blank_q   <= ref_blank_d;
      seen_q        <= seen_d;
      match_q       <= match_d;
      val_q         <= val_d;
      blank_q       <= blank_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
    end
  end

  assign val1        = val_q[3:0];
  assign val2        = val_q[7:4];
  assign val3        = val_q[11:8];
  assign val4        = val_q[15:12];
  assign blank       = blank_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign scan_err    = scan_err_q;

endmodule

// File: doc/ssd_scan_capture.md
# ssd_scan_capture

Passive observer for the multiplexed four-digit seven-segment bus (`led_anodes`/`led_cathodes`) driven by the meter display logic. It samples each scanned digit after the anode settles, decodes the segment pattern back to a BCD code and assembles four-digit frames. Once a frame repeats unchanged it publishes the frame as `val1`..`val4`. It serves as the receive end of the display interface, for on-board self-check and as a bench scoreboard.

## Interface
- `SETTLE`, 4: cycles a single anode must stay unchanged before its cathodes are sampled. Must be at least 1.
- `STABLE_FRAMES`, 2: consecutive identical complete frames required before the outputs update. Must be at least 1.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous and active-low.
- `led_anodes` input 4: active-low digit enables. Bit 0 is the rightmost digit; bit 3 is the leftmost.
- `led_cathodes` input 7: active-low segments. Bit 0 is segment a, through bit 6, which is segment g.
- `val1` output 4: decoded code for the anode[0] digit.
- `val2` output 4: decoded code for the anode[1] digit.
- `val3` output 4: decoded code for the anode[2] digit.
- `val4` output 4: decoded code for the anode[3] digit.
- `blank` output 4: per-digit flag, set when that digit was dark in the published frame.
- `frame_valid` output 1: one-cycle pulse when `val*`/`blank` update.
- `seg_err` output 1: one-cycle pulse when an undecodable pattern is sampled.
- `scan_err` output 1: one-cycle pulse on entry to a multi-hot anode state.

## Operation
- Anode qualifier:
  - Exactly one anode low: state ACTIVE.
  - All anodes high: state IDLE.
  - Two or more anodes low: state IDLE, and `scan_err` pulses on the first cycle of that condition.
- Per-digit FSM has three states: IDLE, SETTLE, HELD.
  - IDLE → SETTLE when a single anode is seen. The settle counter loads 1.
  - In SETTLE, the counter increments each cycle while the same anode and the same cathodes persist.
  - Any change in anode or cathodes restarts the count at 1.
  - If the qualifier drops to IDLE, the FSM returns to IDLE.
  - When the counter reaches `SETTLE`, the FSM samples and moves to HELD.
  - HELD waits for an anode change. A new single anode goes to SETTLE; a drop goes to IDLE. No resample occurs while the anode is unchanged.
- Decode results:
  - Patterns for 0–9 give codes 0–9.
  - All segments off gives code 4'hF with the blank bit set.
  - Any other pattern gives code 4'hE and pulses `seg_err`.
- Frame assembly:
  - Each sample writes its code into the working frame slot and sets that bit in `seen[3:0]`.
  - Revisiting a slot before the frame completes overwrites that slot.
- When `seen` reaches 4'hF:
  - The working frame is compared with the reference frame.
  - Equal: the match count increments, saturating at `STABLE_FRAMES`.
  - Not equal: the reference frame is replaced and the match count is set to 1.
  - `seen` clears.
- Publish: when the match count reaches `STABLE_FRAMES`, `val*`/`blank` load the frame and `frame_valid` pulses.
  - Frames that keep matching beyond that point republish and pulse again, once per frame.
- A flashing display alternates between lit and blank frames. Under this rule it never publishes unless `STABLE_FRAMES`=1.

## Timing
- Reset values: `val1`..`val4`=0, `blank`=0, `frame_valid`=0, `seg_err`=0, `scan_err`=0. All FSMs are in IDLE; `seen`, the match count and the reference frame are cleared.
- A sample is taken on the clock edge on which the settle counter equals `SETTLE`. That is `SETTLE` cycles after the first cycle with the new anode and stable cathodes.
- `seg_err` is registered and asserts in the cycle after the sample edge.
- `val*` and `frame_valid` are registered. They update in the cycle after the sample that completes a qualifying frame.
- An anode dwell shorter than `SETTLE` cycles produces no sample and no error.
- Reset asserted mid-frame discards any partial frame immediately.

## Configuration
- `SSD_CAPTURE_HEX_EN`:
  - When defined, patterns A, b, C, d, E, F decode to 4'hA–4'hF.
  - The invalid-pattern code stays 4'hE, and `seg_err` distinguishes an invalid pattern from a real E.
  - Blank still reports 4'hF with the blank bit set.
  - When undefined, those six patterns are invalid (code 4'hE, `seg_err`).

## Structure
- `ssd_pkg` holds:
  - segment constants `SEG_0`..`SEG_9`, `SEG_A`..`SEG_F`, `SEG_BLANK` (active-low, bit order as above);
  - code constants `DIG_BLANK`=4'hF and `DIG_BAD`=4'hE;
  - the FSM state enum.
- Sub-module `ssd_seg_decode` is purely combinational: a 7-bit pattern in; code, blank and invalid out. It honours `SSD_CAPTURE_HEX_EN`.

## Test plan
- Defaults; scan the digits anode[3]..anode[0] showing 0,1,8,0 with 8-cycle dwell, for 3 frames. Expect one `frame_valid` at the end of frame 2 and one at the end of frame 3, with `val4..val1`=0,1,8,0 and `blank`=0.
- Frames alternating 0180/0179. Expect no `frame_valid`; outputs hold their reset values.
- Anode[1] held only 3 cycles within a frame. Expect no sample for that slot and no `frame_valid` until a later full frame completes.
- Cathodes 7'b1111110 (segment a only) on anode[2]. Expect `seg_err` pulse; published `val3`=4'hE after a stable frame. With `SSD_CAPTURE_HEX_EN`, pattern b gives `val3`=4'hB.
- `led_anodes`=4'b0011 for 5 cycles. Expect a single `scan_err` pulse and no sample.
- Reset pulsed after 3 digits of a frame. Expect outputs 0. The next two complete frames of 0016 then publish `val4..val1`=0,0,1,6.
